// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch stage between the PC register and decode.
// It requests the word at pc over a req/ack handshake and registers it for decode.
// It steers the PC with either the sequential address or an execute redirect.
// A fetch that is in flight when a redirect arrives is discarded.
module fetch_unit #(
    parameter int PC_INC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] target,
    output logic        pc_load,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic        pend;
    logic [31:0] pend_target;

    // Requests come from the state alone; the address tracks the live PC.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // Fetch sequencing, redirect tracking and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SYNC;
            pend        <= 1'b0;
            pend_target <= 32'd0;
            ir          <= 32'd0;
            ir_valid    <= 1'b0;
            target      <= 32'd0;
            pc_load     <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            // pc_load is a strobe: it only rises in the cycle a load is decided.
            pc_load <= 1'b0;
            case (state)
                // One idle cycle lets the PC settle on its start address.
                SYNC: begin
                    state <= REQ;
                end
                // Wait for the memory; a redirect seen meanwhile poisons the word.
                REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            target  <= redirect_target;
                            pc_load <= 1'b1;
                            pend    <= 1'b0;
                            state   <= DRAIN;
                        end else if (pend) begin
                            target  <= pend_target;
                            pc_load <= 1'b1;
                            pend    <= 1'b0;
                            state   <= DRAIN;
                        end else begin
                            ir       <= imem_rdata;
                            ir_valid <= 1'b1;
                            target   <= pc + 32'(PC_INC);
                            pc_load  <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        pend        <= 1'b1;
                        pend_target <= redirect_target;
                    end
                end
                // Present ir until decode takes it; a redirect overrides the
                // next state but never cancels a handshake made in the same cycle.
                HOLD: begin
                    if (ir_valid && ir_ready) begin
                        ir_valid    <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= REQ;
                    end
                    if (redirect) begin
                        ir_valid <= 1'b0;
                        target   <= redirect_target;
                        pc_load  <= 1'b1;
                        state    <= DRAIN;
                    end
                end
                // Give the PC one edge to take the new target before requesting.
                DRAIN: begin
                    if (redirect) begin
                        target  <= redirect_target;
                        pc_load <= 1'b1;
                        state   <= DRAIN;
                    end else begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule
